sha512_msg_sequencer: RTL and testbench
=======================================

// Module: sha512_msg_sequencer
// PURPOSE
//  Sequences one sha512_chunk core across a multi-chunk message. Accepts pre-padded 1024-bit chunks
//  over valid/ready, selects the initial hash value (IV) per message, starts the core via its reset,
//  chains oH back to iH, and presents the final 512-bit digest on a valid/ready output.
//  Sits between the padding/framing front end and the core inside sha512_top.
// PARAMETERS
//  CORE_TIMEOUT  127  max RUN cycles before abort; nominal core run is 83 cycles; must be >= 90
// PORTS
//  clk          in   1     clock
//  reset        in   1     asynchronous, active-low
//  s_valid      in   1     chunk offered
//  s_ready      out  1     chunk accepted when s_valid&&s_ready
//  s_chunk      in   1024  padded chunk, word 0 in [1023:960]
//  s_first      in   1     chunk starts a message (load IV)
//  s_last       in   1     chunk ends a message (emit digest)
//  s_mode384    in   1     sampled with s_first: 1=SHA-384 IV and truncation, 0=SHA-512
//  m_valid      out  1     digest available
//  m_ready      in   1     digest consumed when m_valid&&m_ready
//  m_digest     out  512   H0 in [511:448]; SHA-384: [127:0] forced to 0
//  core_rst_n   out  1     drives core reset; low holds core in BIRTH
//  core_chunk   out  1024  registered chunk to core
//  core_ih      out  512   registered running hash to core iH (H0 msb)
//  core_oh      in   512   core oH
//  core_done    in   1     core done
//  busy         out  1     high in any state but IDLE
//  err_proto    out  1     sticky: continuation chunk with no open message
//  err_timeout  out  1     sticky: core exceeded CORE_TIMEOUT
// BEHAVIOUR
//  Reset values: all outputs 0, including core_rst_n=0, m_digest=0, and both error flags. State=IDLE;
//   open-message flag=0. Reset is asynchronous and is honoured in any state. Reset mid-RUN or
//   mid-OUT discards all work with no digest.
//  FSM states: IDLE, LOAD, RUN, UPDATE, OUT.
//   IDLE: s_ready=1. On handshake, capture the chunk into chunk_r and last_r.
//    If s_first: H_r<=IV(s_mode384), mode_r<=s_mode384, open<=1.
//    If !s_first and open: H_r is kept.
//    If !s_first and !open: load the SHA-512 IV, set open<=1, set err_proto<=1.
//    Go to LOAD.
//   LOAD: one cycle with core_rst_n=0, which guarantees a clean core restart. Go to RUN; clear tcnt.
//   RUN: core_rst_n=1; tcnt++.
//    On core_done: go to UPDATE.
//    On tcnt==CORE_TIMEOUT without done: err_timeout<=1, open<=0, go to IDLE.
//   UPDATE: H_r<=core_oh; core_rst_n=0.
//    If last_r: open<=0, m_digest<=core_oh (masked if mode_r), go to OUT.
//    Otherwise go to IDLE.
//   OUT: m_valid=1; m_digest is stable until the handshake. On m_ready go to IDLE.
//  core_rst_n is a flop output, glitch-free, and is 1 only in RUN.
//   core_chunk and core_ih come straight from chunk_r and H_r and are stable for all of LOAD..UPDATE.
//  s_ready=0 outside IDLE; one chunk is in flight at a time. m_valid=1 only in OUT.
//  Latency, handshake to m_valid for a single-chunk message: 1 (LOAD) + N_run + 1 (UPDATE) cycles,
//   where N_run = RUN cycles up to done (83 nominal). Budget 86 cycles.
//  s_first && s_last together forms a one-chunk message.
//  s_first while open: the old message is abandoned silently and the IV is reloaded.
//  Arithmetic: none locally; all 64-bit adds are in the core. The timeout counter tcnt is 8 bits and saturates.
//  busy=(state!=IDLE). Error flags clear only on reset.
// STRUCTURE
//  Package sha512_pkg: IV512[0:7] and IV384[0:7] (64-bit each), state enum seq_state_t,
//   DIGEST_W=512, CHUNK_W=1024.
//  No sub-module inside. sha512_top instantiates this block plus sha512_chunk and wires the core_* ports.
//  The bench instantiates the same pair and adds a stub core for the timeout test.
// TESTING
//  1 SHA-512 "abc": chunk=616263800..0 with length 0x18, first=last=1
//    -> m_digest[511:448]=ddaf35a193617aba, [63:0]=a54ca49f, m_valid within 86 cycles.
//  2 SHA-384 "abc", mode384=1 -> m_digest[511:448]=cb00753f45a35e8b; [127:0]=0.
//  3 896-bit NIST two-block message "abcdefghbcdefghi..."
//    -> s_ready deasserts between chunks; digest[511:448]=8e959b75dae313da.
//  4 Hold m_ready=0 for 20 cycles in OUT -> m_valid and m_digest stable; s_ready=0;
//    on release return to IDLE, s_ready=1 next cycle.
//  5 Assert reset during RUN cycle 40 -> all outputs 0 immediately; resend test 1 -> correct digest.
//  6 Stub core never asserts done -> err_timeout=1 at RUN cycle CORE_TIMEOUT, back to IDLE.
//    A continuation chunk with first=0 then sets err_proto=1.

Source files
------------

// File: rtl/sha512_msg_sequencer_pkg.sv
// Shared types and constants for the SHA-512 multi-chunk message sequencer.
// Hash words are ordered H0..H7 from msb to lsb so H0 lands in [511:448].
package sha512_msg_sequencer_pkg;

    localparam int DIGEST_W = 512;
    localparam int CHUNK_W  = 1024;
    localparam int WORD_W   = 64;

    typedef logic [0:7][WORD_W-1:0] hash_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RUN    = 3'd2,
        UPDATE = 3'd3,
        OUT    = 3'd4
    } seq_state_t;

    localparam hash_t IV512 = {
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
    };

    localparam hash_t IV384 = {
        64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507, 64'h9159015a3070dd17, 64'h152fecd8f70e5939,
        64'h67332667ffc00b31, 64'h8eb44a8768581511, 64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4
    };

    function automatic hash_t iv_sel(input logic mode384);
        return mode384 ? IV384 : IV512;
    endfunction

    // SHA-384 keeps H0..H5; the two low words are zeroed on the output only.
    function automatic hash_t trunc384(input hash_t h);
        hash_t r;
        r    = h;
        r[6] = '0;
        r[7] = '0;
        return r;
    endfunction

endpackage

// File: rtl/sha512_msg_sequencer_if.sv
// Chunk-in / digest-out valid/ready bundle of the message sequencer.
interface sha512_msg_sequencer_if;
    import sha512_msg_sequencer_pkg::*;

    logic                s_valid;
    logic                s_ready;
    logic [CHUNK_W-1:0]  s_chunk;
    logic                s_first;
    logic                s_last;
    logic                s_mode384;

    logic                m_valid;
    logic                m_ready;
    logic [DIGEST_W-1:0] m_digest;

    modport master (
        output s_valid, s_chunk, s_first, s_last, s_mode384, m_ready,
        input  s_ready, m_valid, m_digest
    );

    modport slave (
        input  s_valid, s_chunk, s_first, s_last, s_mode384, m_ready,
        output s_ready, m_valid, m_digest
    );

endinterface

// File: rtl/sha512_msg_sequencer.sv
// Drives one sha512_chunk core across a multi-chunk message: IV select, core restart,
// oH->iH chaining, timeout abort and final digest hand-off. All outputs are registered.
module sha512_msg_sequencer
    import sha512_msg_sequencer_pkg::*;
#(
    parameter int CORE_TIMEOUT = 127   // keep within 90..255; tcnt is 8 bits
) (
    input  logic                clk,
    input  logic                reset,
    sha512_msg_sequencer_if.slave bus,
    output logic                core_rst_n,
    output logic [CHUNK_W-1:0]  core_chunk,
    output logic [DIGEST_W-1:0] core_ih,
    input  logic [DIGEST_W-1:0] core_oh,
    input  logic                core_done,
    output logic                busy,
    output logic                err_proto,
    output logic                err_timeout
);

    // tcnt holds the number of completed RUN cycles, so this value marks the last allowed one.
    localparam logic [7:0] TMO_LAST = 8'(CORE_TIMEOUT - 1);

    seq_state_t         state;
    logic [CHUNK_W-1:0] chunk_r;
    hash_t              h_r;
    logic               last_r;
    logic               mode_r;
    logic               open_r;
    logic [7:0]         tcnt;
    logic               s_hs;

    assign s_hs       = bus.s_valid && bus.s_ready;
    assign core_chunk = chunk_r;
    assign core_ih    = h_r;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            chunk_r      <= '0;
            h_r          <= '0;
            last_r       <= 1'b0;
            mode_r       <= 1'b0;
            open_r       <= 1'b0;
            tcnt         <= '0;
            core_rst_n   <= 1'b0;
            busy         <= 1'b0;
            err_proto    <= 1'b0;
            err_timeout  <= 1'b0;
            bus.s_ready  <= 1'b0;
            bus.m_valid  <= 1'b0;
            bus.m_digest <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_hs) begin
                        chunk_r <= bus.s_chunk;
                        last_r  <= bus.s_last;
                        open_r  <= 1'b1;
                        if (bus.s_first) begin
                            h_r    <= iv_sel(bus.s_mode384);
                            mode_r <= bus.s_mode384;
                        end else if (!open_r) begin
                            // Orphan continuation: run it as a fresh SHA-512 message and flag it.
                            h_r       <= IV512;
                            mode_r    <= 1'b0;
                            err_proto <= 1'b1;
                        end
                        bus.s_ready <= 1'b0;
                        busy        <= 1'b1;
                        state       <= LOAD;
                    end else begin
                        bus.s_ready <= 1'b1;
                    end
                end

                LOAD: begin
                    core_rst_n <= 1'b1;
                    tcnt       <= '0;
                    state      <= RUN;
                end

                RUN: begin
                    tcnt <= (tcnt == 8'hff) ? tcnt : tcnt + 8'd1;
                    if (core_done) begin
                        core_rst_n <= 1'b0;
                        state      <= UPDATE;
                    end else if (tcnt == TMO_LAST) begin
                        core_rst_n  <= 1'b0;
                        err_timeout <= 1'b1;
                        open_r      <= 1'b0;
                        busy        <= 1'b0;
                        bus.s_ready <= 1'b1;
                        state       <= IDLE;
                    end
                end

                UPDATE: begin
                    h_r <= core_oh;
                    if (last_r) begin
                        open_r       <= 1'b0;
                        bus.m_digest <= mode_r ? trunc384(core_oh) : core_oh;
                        bus.m_valid  <= 1'b1;
                        state        <= OUT;
                    end else begin
                        busy        <= 1'b0;
                        bus.s_ready <= 1'b1;
                        state       <= IDLE;
                    end
                end

                OUT: begin
                    if (bus.m_ready) begin
                        bus.m_valid <= 1'b0;
                        busy        <= 1'b0;
                        bus.s_ready <= 1'b1;
                        state       <= IDLE;
                    end
                end

                default: begin
                    core_rst_n  <= 1'b0;
                    busy        <= 1'b0;
                    bus.m_valid <= 1'b0;
                    bus.s_ready <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha512_msg_sequencer.sv
// Bench for sha512_msg_sequencer with a behavioural 83-cycle SHA-512 core beside it.
// Digests go into a queue when their final chunk is sent and are checked when m_valid fires.
module tb_sha512_msg_sequencer;
    import sha512_msg_sequencer_pkg::*;

    localparam int TMO = 127;

    typedef struct {
        logic [1023:0] chunk;
        logic          first;
        logic          last;
        logic          mode;
        logic [63:0]   exp_hi;
        logic [31:0]   exp_lo;
        logic          chk_lo;
        logic          trunc;
        int            id;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          core_rst_n, core_done, busy, err_proto, err_timeout;
    logic [1023:0] core_chunk;
    logic [511:0]  core_ih;
    logic [511:0]  core_oh;
    logic [511:0]  moh = '0;
    logic [7:0]    mcnt;
    logic          stub_hang;

    int   checks = 0;
    int   errors = 0;
    vec_t vec[4];
    vec_t exp_q[$];

    sha512_msg_sequencer_if bus();

    sha512_msg_sequencer #(.CORE_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave),
        .core_rst_n(core_rst_n), .core_chunk(core_chunk), .core_ih(core_ih),
        .core_oh(core_oh), .core_done(core_done),
        .busy(busy), .err_proto(err_proto), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    localparam logic [63:0] K [0:79] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
    };

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // One SHA-512 compression plus feed-forward, i.e. what the core reports on oH.
    function automatic logic [511:0] sha512_blk(input logic [511:0] ih, input logic [1023:0] blk);
        logic [63:0] w [0:79];
        logic [63:0] hv [0:7];
        logic [63:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        for (int i = 0; i < 8; i++)  hv[i] = ih[511-64*i -: 64];
        for (int i = 0; i < 16; i++) w[i]  = blk[1023-64*i -: 64];
        for (int i = 16; i < 80; i++) begin
            s0   = rotr(w[i-15], 1) ^ rotr(w[i-15], 8) ^ (w[i-15] >> 7);
            s1   = rotr(w[i-2], 19) ^ rotr(w[i-2], 61) ^ (w[i-2] >> 6);
            w[i] = s1 + w[i-7] + s0 + w[i-16];
        end
        a = hv[0]; b = hv[1]; c = hv[2]; d = hv[3];
        e = hv[4]; f = hv[5]; g = hv[6]; h = hv[7];
        for (int i = 0; i < 80; i++) begin
            t1 = h + (rotr(e, 14) ^ rotr(e, 18) ^ rotr(e, 41)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (rotr(a, 28) ^ rotr(a, 34) ^ rotr(a, 39)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1;
            d = c; c = b; b = a; a = t1 + t2;
        end
        return {hv[0] + a, hv[1] + b, hv[2] + c, hv[3] + d,
                hv[4] + e, hv[5] + f, hv[6] + g, hv[7] + h};
    endfunction

    // Core model: done in the 83rd cycle after reset release; stub_hang suppresses done.
    always @(posedge clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            mcnt <= 8'd0;
        end else begin
            if (mcnt == 8'd0) moh <= sha512_blk(core_ih, core_chunk);
            if (mcnt != 8'hff) mcnt <= mcnt + 8'd1;
        end
    end
    assign core_done = core_rst_n && !stub_hang && (mcnt == 8'd82);
    assign core_oh   = moh;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard: every digest handshake must match the oldest pending expectation.
    always @(negedge clk) begin
        if (reset === 1'b1 && bus.m_valid && bus.m_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_digest: got %0h expected none", bus.m_digest[511:448]);
            end else begin
                vec_t e;
                e = exp_q.pop_front();
                chk($sformatf("digest_hi[%0d]", e.id), 512'(bus.m_digest[511:448]), 512'(e.exp_hi));
                if (e.chk_lo) chk($sformatf("digest_lo[%0d]", e.id), 512'(bus.m_digest[31:0]), 512'(e.exp_lo));
                if (e.trunc)  chk($sformatf("trunc_zero[%0d]", e.id), 512'(bus.m_digest[127:0]), 512'd0);
            end
        end
    end

    task automatic send(input vec_t v);
        int n;
        n = 0;
        bus.s_valid   = 1'b1;
        bus.s_chunk   = v.chunk;
        bus.s_first   = v.first;
        bus.s_last    = v.last;
        bus.s_mode384 = v.mode;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.s_ready && n < 400);
        if (!bus.s_ready) chk("send_timeout", 512'(bus.s_ready), 512'd1);
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
    endtask

    // Counts cycles from the handshake edge to m_valid; returns 999 if it never arrives.
    task automatic wait_mvalid(output int n);
        n = 0;
        while (!bus.m_valid && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.m_valid) n = 999;
    endtask

    initial begin
        logic [1023:0] c1;
        logic [511:0]  dig;
        vec_t          orphan;
        int            n, run_cnt;

        reset = 1'b0;
        stub_hang = 1'b0;
        bus.s_valid = 1'b0; bus.s_chunk = '0; bus.s_first = 1'b0;
        bus.s_last = 1'b0; bus.s_mode384 = 1'b0; bus.m_ready = 1'b1;

        c1 = '0;
        for (int g = 0; g < 14; g++)
            for (int j = 0; j < 8; j++)
                c1[1023-8*(8*g+j) -: 8] = 8'h61 + 8'(g + j);
        c1[1023-8*112 -: 8] = 8'h80;

        vec[0] = '{{32'h61626380, 864'd0, 128'h18}, 1'b1, 1'b1, 1'b0,
                   64'hddaf35a193617aba, 32'ha54ca49f, 1'b1, 1'b0, 0};
        vec[1] = '{{32'h61626380, 864'd0, 128'h18}, 1'b1, 1'b1, 1'b1,
                   64'hcb00753f45a35e8b, 32'h0, 1'b0, 1'b1, 1};
        vec[2] = '{c1, 1'b1, 1'b0, 1'b0, 64'h0, 32'h0, 1'b0, 1'b0, 2};
        vec[3] = '{{896'd0, 128'd896}, 1'b0, 1'b1, 1'b0,
                   64'h8e959b75dae313da, 32'h874be909, 1'b1, 1'b0, 3};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_ready", 512'(bus.s_ready), 512'd0);
        chk("rst_m_valid", 512'(bus.m_valid), 512'd0);
        chk("rst_m_digest", bus.m_digest, 512'd0);
        chk("rst_core_rst_n", 512'(core_rst_n), 512'd0);
        chk("rst_core_ih", core_ih, 512'd0);
        chk("rst_busy_errs", 512'({busy, err_proto, err_timeout}), 512'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_s_ready", 512'(bus.s_ready), 512'd1);

        // Table: SHA-512 abc, SHA-384 abc, then the two-block message.
        for (int v = 0; v < 4; v++) begin
            if (vec[v].last) exp_q.push_back(vec[v]);
            send(vec[v]);
            if (!vec[v].last) begin
                chk($sformatf("mid_s_ready[%0d]", v), 512'(bus.s_ready), 512'd0);
                chk($sformatf("mid_busy[%0d]", v), 512'(busy), 512'd1);
                chk($sformatf("mid_core_ih[%0d]", v), core_ih, 512'(IV512));
            end else begin
                wait_mvalid(n);
                chk($sformatf("latency[%0d]", v), 512'(n), 512'd85);
                @(posedge clk);
                #1;
            end
        end

        // Digest held in OUT while m_ready is low.
        bus.m_ready = 1'b0;
        exp_q.push_back(vec[0]);
        send(vec[0]);
        wait_mvalid(n);
        chk("hold_latency", 512'(n), 512'd85);
        dig = bus.m_digest;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("hold_m_valid", 512'(bus.m_valid), 512'd1);
            chk("hold_m_digest", bus.m_digest, dig);
            chk("hold_s_ready", 512'(bus.s_ready), 512'd0);
        end
        @(posedge clk);
        #1;
        bus.m_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_s_ready", 512'(bus.s_ready), 512'd1);
        chk("release_m_valid", 512'(bus.m_valid), 512'd0);

        // Reset in RUN cycle 40 discards the message.
        exp_q.push_back(vec[0]);
        send(vec[0]);
        repeat (40) @(posedge clk);
        #2;
        chk("run40_core_rst_n", 512'(core_rst_n), 512'd1);
        reset = 1'b0;
        #1;
        exp_q.delete();
        chk("arst_outputs", 512'({bus.s_ready, bus.m_valid, core_rst_n, busy, err_proto, err_timeout}), 512'd0);
        chk("arst_m_digest", bus.m_digest, 512'd0);
        chk("arst_core_chunk", 512'(core_chunk[1023:512] | core_chunk[511:0]), 512'd0);
        chk("arst_core_ih", core_ih, 512'd0);
        @(negedge clk);
        reset = 1'b1;
        exp_q.push_back(vec[0]);
        send(vec[0]);
        wait_mvalid(n);
        chk("post_rst_latency", 512'(n), 512'd85);
        @(posedge clk);
        #1;

        // Core never finishes: abort after exactly TMO RUN cycles.
        stub_hang = 1'b1;
        send(vec[0]);
        run_cnt = 0;
        n = 0;
        do begin
            @(negedge clk);
            if (core_rst_n) run_cnt++;
            n++;
        end while (busy && n < 400);
        chk("tmo_run_cycles", 512'(run_cnt), 512'(TMO));
        chk("tmo_err_timeout", 512'(err_timeout), 512'd1);
        chk("tmo_idle", 512'({busy, bus.s_ready, err_proto}), 512'b010);
        stub_hang = 1'b0;

        // Orphan continuation: SHA-512 IV regardless of mode, err_proto raised.
        orphan = vec[0];
        orphan.first = 1'b0;
        orphan.mode = 1'b1;
        orphan.id = 4;
        exp_q.push_back(orphan);
        send(orphan);
        chk("orphan_err_proto", 512'(err_proto), 512'd1);
        chk("orphan_core_ih", core_ih, 512'(IV512));
        wait_mvalid(n);
        chk("orphan_latency", 512'(n), 512'd85);
        chk("errs_sticky", 512'({err_proto, err_timeout}), 512'b11);

        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk("queue_drained", 512'(exp_q.size()), 512'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
